corevx_tlb: RTL and testbench
=============================

// Module: corevx_tlb
// PURPOSE
//  Fully associative translation cache in front of corevx_ptw. Takes 20-bit VPN requests from the
//  fetch/load-store side, answers hits from local entries and, on miss, drives one walk on the
//  corevx_ptw resolve_* interface, fills an entry on success and returns the result.
//  One translation outstanding at a time. Fault results are returned, never cached.
// PARAMETERS
//  ENTRIES_W  3  log2 of entry count (8 entries); victim pointer is ENTRIES_W bits wide
// PORTS
//  clk                       in   1   clock; all state updates on rising edge
//  rst                       in   1   asynchronous, active-high reset
//  req_valid                 in   1   translation request
//  req_vpn                   in   20  virtual page number (VA[31:12])
//  req_ready                 out  1   request accepted on an edge where req_valid&&req_ready
//  rsp_valid                 out  1   one-cycle pulse, response fields valid
//  rsp_hit                   out  1   1 = served from TLB, 0 = served by a walk
//  rsp_physical_address      out  22  PPN as returned by PTW (megapage low 10 bits already 0)
//  rsp_access_bits           out  8   PTE bits [7:0] (D A G U X W R V)
//  rsp_pagefault             out  1   walk reported pagefault
//  rsp_accessfault           out  1   walk reported accessfault
//  invalidate                in   1   flush all entries (sfence.vma)
//  resolve_request           out  1   to PTW; held high until resolve_done
//  resolve_virtual_address   out  32  to PTW; {vpn, 12'h000}
//  resolve_done              in   1   PTW walk complete (one cycle)
//  resolve_pagefault         in   1   PTW result, valid with resolve_done
//  resolve_accessfault       in   1   PTW result, valid with resolve_done
//  resolve_access_bits       in   8   PTW result, valid with resolve_done
//  resolve_physical_address  in   22  PTW result, valid with resolve_done
// BEHAVIOUR
//  Reset: state IDLE; all entry valid bits 0; victim ptr 0; req_ready 1; rsp_* 0; resolve_request 0;
//   resolve_virtual_address 0. Reset mid-walk drops resolve_request immediately (PTW shares rst).
//  Entry: {valid, vpn[19:0], ppn[21:0], access_bits[7:0]}; tag is full VPN (megapages cached per 4K VPN).
//  FSM: IDLE -> LOOKUP -> RESP (hit) | WALK (miss); WALK -> RESP on resolve_done; RESP -> IDLE.
//  IDLE: req_ready=1; on req_valid latch req_vpn, go LOOKUP. req_ready=0 in all other states.
//  LOOKUP: compare latched VPN against all valid entries in one cycle. Hit: register entry fields,
//   rsp_hit=1, faults 0 -> RESP. Miss -> WALK. At most one entry can match (fill only after miss).
//  WALK: resolve_request=1, resolve_virtual_address={vpn,12'h0}, both stable until resolve_done
//   sampled high. On done: register PTW fields, rsp_hit=0 -> RESP. If neither fault and no flush
//   pending: write entry[victim], victim <= victim+1 (wraps 2^ENTRIES_W-1 -> 0), valid-or-not.
//  RESP: rsp_valid=1 for exactly one cycle; rsp_* hold value until next RESP (not cleared).
//  Latency: hit = rsp_valid in 2nd cycle after accept edge; miss = cycle after resolve_done.
//  invalidate: clears all valid bits at next edge in any state; priority over fill in same cycle.
//   In LOOKUP same cycle: treated as miss. In WALK: sets flush flag; walk completes, response
//   delivered, fill suppressed; flag cleared on leaving RESP. Victim ptr not reset by invalidate.
//  resolve_ack ignored (not connected). PTW fault with both bits: both reported, no fill.
// TESTING
//  1 Cold miss: req_vpn=20'h00401, PTW returns ppn 22'h00123 bits 8'h0F -> resolve_virtual_address
//    32'h00401000, rsp_hit=0, rsp_physical_address=22'h00123; repeat -> rsp_hit=1, 2-cycle, no walk.
//  2 Pagefault: PTW returns pagefault for VPN 20'h00005 -> rsp_pagefault=1; repeat re-walks (not cached).
//  3 Accessfault: same as 2 with accessfault -> rsp_accessfault=1, rsp_pagefault=0, re-walk on repeat.
//  4 Replacement: 9 distinct VPNs 0..8 filled (ENTRIES_W=3) -> VPN 0 misses, VPNs 1..8 hit.
//  5 Invalidate: 1-cycle pulse during WALK for VPN 20'h00010 -> response delivered, repeat misses;
//    pulse in IDLE after fills -> all previously cached VPNs miss.
//  6 Reset asserted mid-WALK -> resolve_request 0 same cycle, req_ready 1, earlier cached VPN misses.

Source files
------------

// File: rtl/corevx_tlb_if.sv
// Request/response and PTW-resolve signal bundle for corevx_tlb.
// The slave modport is the TLB's view; the master modport drives requests and plays the PTW.
interface corevx_tlb_if;
    logic        req_valid;
    logic [19:0] req_vpn;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [21:0] rsp_physical_address;
    logic [7:0]  rsp_access_bits;
    logic        rsp_pagefault;
    logic        rsp_accessfault;
    logic        invalidate;
    logic        resolve_request;
    logic [31:0] resolve_virtual_address;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [7:0]  resolve_access_bits;
    logic [21:0] resolve_physical_address;

    modport slave (
        input  req_valid, req_vpn, invalidate,
        input  resolve_done, resolve_pagefault, resolve_accessfault,
        input  resolve_access_bits, resolve_physical_address,
        output req_ready, rsp_valid, rsp_hit, rsp_physical_address, rsp_access_bits,
        output rsp_pagefault, rsp_accessfault, resolve_request, resolve_virtual_address
    );

    modport master (
        output req_valid, req_vpn, invalidate,
        output resolve_done, resolve_pagefault, resolve_accessfault,
        output resolve_access_bits, resolve_physical_address,
        input  req_ready, rsp_valid, rsp_hit, rsp_physical_address, rsp_access_bits,
        input  rsp_pagefault, rsp_accessfault, resolve_request, resolve_virtual_address
    );
endinterface

// File: rtl/corevx_tlb.sv
// Fully associative TLB in front of corevx_ptw: one translation in flight, round-robin fill,
// faults are returned but never cached.
module corevx_tlb #(
    parameter int unsigned ENTRIES_W = 3
) (
    input logic         clk,
    input logic         rst,
    corevx_tlb_if.slave bus
);

    localparam int unsigned Entries = 1 << ENTRIES_W;

    typedef enum logic [1:0] {StIdle, StLookup, StWalk, StResp} state_e;

    state_e               state_q;
    logic [19:0]          vpn_q;
    logic [Entries-1:0]   valid_q;
    logic [19:0]          tag_q  [Entries];
    logic [21:0]          ppn_q  [Entries];
    logic [7:0]           bits_q [Entries];
    logic [ENTRIES_W-1:0] victim_q;
    logic                 flush_q;

    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_hit_q;
    logic [21:0] rsp_pa_q;
    logic [7:0]  rsp_bits_q;
    logic        rsp_pf_q;
    logic        rsp_af_q;
    logic        resolve_req_q;
    logic [31:0] resolve_va_q;

    logic                 hit;
    logic [ENTRIES_W-1:0] hit_idx;
    logic                 fill_ok;

    // Fills only happen after a miss, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < Entries; i++) begin
            if (valid_q[i] && (tag_q[i] == vpn_q)) begin
                hit     = 1'b1;
                hit_idx = ENTRIES_W'(i);
            end
        end
    end

    assign fill_ok = !bus.resolve_pagefault && !bus.resolve_accessfault &&
                     !flush_q && !bus.invalidate;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            vpn_q         <= '0;
            valid_q       <= '0;
            victim_q      <= '0;
            flush_q       <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_pa_q      <= '0;
            rsp_bits_q    <= '0;
            rsp_pf_q      <= 1'b0;
            rsp_af_q      <= 1'b0;
            resolve_req_q <= 1'b0;
            resolve_va_q  <= '0;
            for (int i = 0; i < Entries; i++) begin
                tag_q[i]  <= '0;
                ppn_q[i]  <= '0;
                bits_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        vpn_q       <= bus.req_vpn;
                        req_ready_q <= 1'b0;
                        state_q     <= StLookup;
                    end
                end
                StLookup: begin
                    // A flush landing on the lookup cycle forces a walk.
                    if (hit && !bus.invalidate) begin
                        rsp_hit_q   <= 1'b1;
                        rsp_pa_q    <= ppn_q[hit_idx];
                        rsp_bits_q  <= bits_q[hit_idx];
                        rsp_pf_q    <= 1'b0;
                        rsp_af_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        resolve_req_q <= 1'b1;
                        resolve_va_q  <= {vpn_q, 12'h000};
                        state_q       <= StWalk;
                    end
                end
                StWalk: begin
                    if (bus.invalidate) begin
                        flush_q <= 1'b1;
                    end
                    if (bus.resolve_done) begin
                        resolve_req_q <= 1'b0;
                        rsp_hit_q     <= 1'b0;
                        rsp_pa_q      <= bus.resolve_physical_address;
                        rsp_bits_q    <= bus.resolve_access_bits;
                        rsp_pf_q      <= bus.resolve_pagefault;
                        rsp_af_q      <= bus.resolve_accessfault;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
                        if (fill_ok) begin
                            valid_q[victim_q] <= 1'b1;
                            tag_q[victim_q]   <= vpn_q;
                            ppn_q[victim_q]   <= bus.resolve_physical_address;
                            bits_q[victim_q]  <= bus.resolve_access_bits;
                            victim_q          <= victim_q + 1'b1;
                        end
                    end
                end
                StResp: begin
                    rsp_valid_q <= 1'b0;
                    flush_q     <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            if (bus.invalidate) begin
                valid_q <= '0;
            end
        end
    end

    assign bus.req_ready               = req_ready_q;
    assign bus.rsp_valid               = rsp_valid_q;
    assign bus.rsp_hit                 = rsp_hit_q;
    assign bus.rsp_physical_address    = rsp_pa_q;
    assign bus.rsp_access_bits         = rsp_bits_q;
    assign bus.rsp_pagefault           = rsp_pf_q;
    assign bus.rsp_accessfault         = rsp_af_q;
    assign bus.resolve_request         = resolve_req_q;
    assign bus.resolve_virtual_address = resolve_va_q;

endmodule

// File: tb/tb_corevx_tlb.sv
// Randomized bench for corevx_tlb: the bench plays requester and PTW and predicts every
// response from a slot-array model of the cache with round-robin replacement.
module tb_corevx_tlb;

    logic clk;
    logic rst;

    corevx_tlb_if bus ();

    corevx_tlb #(
        .ENTRIES_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 8 slots, fill pointer advances per successful fill.
    logic [19:0] m_vpn  [8];
    logic [21:0] m_ppn  [8];
    logic [7:0]  m_bits [8];
    bit          m_valid[8];
    int          m_victim;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_find(input logic [19:0] vpn);
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_vpn[i] == vpn) return i;
        end
        return -1;
    endfunction

    task automatic m_flush();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic m_reset();
        m_flush();
        m_victim = 0;
    endtask

    task automatic do_req(input logic [19:0] vpn, input logic [21:0] ppn, input logic [7:0] bits,
                          input bit pf, input bit af, input int delay, input bit inv_walk);
        int idx;
        idx = m_find(vpn);
        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_vpn   = vpn;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_vpn   = 20'($urandom);
        check("req_ready_busy", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        if (idx >= 0) begin
            check("hit_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("hit_rsp_hit", 64'(bus.rsp_hit), 64'd1);
            check("hit_pa", 64'(bus.rsp_physical_address), 64'(m_ppn[idx]));
            check("hit_bits", 64'(bus.rsp_access_bits), 64'(m_bits[idx]));
            check("hit_faults", 64'({bus.rsp_pagefault, bus.rsp_accessfault}), 64'd0);
            check("hit_no_walk", 64'(bus.resolve_request), 64'd0);
        end else begin
            check("miss_no_rsp", 64'(bus.rsp_valid), 64'd0);
            check("walk_request", 64'(bus.resolve_request), 64'd1);
            check("walk_va", 64'(bus.resolve_virtual_address), 64'({vpn, 12'h000}));
            for (int c = 0; c <= delay; c++) begin
                if (c == 0 && inv_walk) bus.invalidate = 1'b1;
                if (c == delay) begin
                    bus.resolve_done             = 1'b1;
                    bus.resolve_pagefault        = pf;
                    bus.resolve_accessfault      = af;
                    bus.resolve_physical_address = ppn;
                    bus.resolve_access_bits      = bits;
                end
                @(posedge clk);
                #1;
                bus.invalidate               = 1'b0;
                bus.resolve_done             = 1'b0;
                bus.resolve_pagefault        = 1'($urandom);
                bus.resolve_accessfault      = 1'($urandom);
                bus.resolve_physical_address = 22'($urandom);
                bus.resolve_access_bits      = 8'($urandom);
                if (c < delay) begin
                    check("walk_hold_req", 64'(bus.resolve_request), 64'd1);
                    check("walk_hold_va", 64'(bus.resolve_virtual_address), 64'({vpn, 12'h000}));
                    check("walk_no_rsp", 64'(bus.rsp_valid), 64'd0);
                end
            end
            check("walk_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("walk_rsp_hit", 64'(bus.rsp_hit), 64'd0);
            check("walk_pa", 64'(bus.rsp_physical_address), 64'(ppn));
            check("walk_bits", 64'(bus.rsp_access_bits), 64'(bits));
            check("walk_pf", 64'(bus.rsp_pagefault), 64'(pf));
            check("walk_af", 64'(bus.rsp_accessfault), 64'(af));
            check("walk_req_drop", 64'(bus.resolve_request), 64'd0);
            if (inv_walk) m_flush();
            if (!pf && !af && !inv_walk) begin
                m_valid[m_victim] = 1'b1;
                m_vpn[m_victim]   = vpn;
                m_ppn[m_victim]   = ppn;
                m_bits[m_victim]  = bits;
                m_victim          = (m_victim + 1) % 8;
            end
        end
        @(posedge clk);
        #1;
        check("rsp_pulse_end", 64'(bus.rsp_valid), 64'd0);
        check("req_ready_back", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic ok_req(input logic [19:0] vpn);
        do_req(vpn, 22'($urandom), 8'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 3)), 1'b0);
    endtask

    task automatic pulse_inv();
        bus.invalidate = 1'b1;
        @(posedge clk);
        #1;
        bus.invalidate = 1'b0;
        m_flush();
        check("inv_idle_ready", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic reset_mid_walk(input logic [19:0] vpn);
        check("mw_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_vpn   = vpn;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mw_walking", 64'(bus.resolve_request), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mw_req_drop", 64'(bus.resolve_request), 64'd0);
        check("mw_ready_rst", 64'(bus.req_ready), 64'd1);
        check("mw_va_rst", 64'(bus.resolve_virtual_address), 64'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int r;
        rst                          = 1'b1;
        bus.req_valid                = 1'b0;
        bus.req_vpn                  = '0;
        bus.invalidate               = 1'b0;
        bus.resolve_done             = 1'b0;
        bus.resolve_pagefault        = 1'b0;
        bus.resolve_accessfault      = 1'b0;
        bus.resolve_access_bits      = '0;
        bus.resolve_physical_address = '0;
        m_reset();
        @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_fields", 64'({bus.rsp_hit, bus.rsp_physical_address, bus.rsp_access_bits,
                                     bus.rsp_pagefault, bus.rsp_accessfault}), 64'd0);
        check("rst_resolve_req", 64'(bus.resolve_request), 64'd0);
        check("rst_resolve_va", 64'(bus.resolve_virtual_address), 64'd0);
        rst = 1'b0;

        // Cold miss then hit.
        do_req(20'h00401, 22'h00123, 8'h0F, 1'b0, 1'b0, 2, 1'b0);
        do_req(20'h00401, 22'h3FFFF, 8'hAA, 1'b0, 1'b0, 0, 1'b0);
        // Faults are not cached.
        do_req(20'h00005, 22'h00777, 8'h01, 1'b1, 1'b0, 1, 1'b0);
        do_req(20'h00005, 22'h00777, 8'h01, 1'b1, 1'b0, 0, 1'b0);
        do_req(20'h00006, 22'h00888, 8'h03, 1'b0, 1'b1, 1, 1'b0);
        do_req(20'h00006, 22'h00888, 8'h03, 1'b0, 1'b1, 3, 1'b0);
        do_req(20'h00007, 22'h00999, 8'h07, 1'b1, 1'b1, 0, 1'b0);

        // Replacement wraps after 8 fills.
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int v = 0; v <= 8; v++) ok_req(20'(v));
        for (int v = 1; v <= 8; v++) ok_req(20'(v));
        ok_req(20'h00000);

        // Flush during a walk, then flush in idle.
        do_req(20'h00010, 22'h01010, 8'h0F, 1'b0, 1'b0, 2, 1'b1);
        ok_req(20'h00010);
        do_req(20'h00011, 22'h01011, 8'h0F, 1'b0, 1'b0, 0, 1'b1);
        ok_req(20'h00020);
        ok_req(20'h00021);
        ok_req(20'h00020);
        pulse_inv();
        ok_req(20'h00020);
        ok_req(20'h00021);

        // Reset in the middle of a walk.
        ok_req(20'h00030);
        reset_mid_walk(20'h00031);
        ok_req(20'h00030);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) pulse_inv();
            do_req(20'($urandom_range(0, 11)), 22'($urandom), 8'($urandom),
                   (r == 0) || (r == 2), (r == 1) || (r == 2),
                   int'($urandom_range(0, 4)), $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
